// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared types and constants for the register-bank writeback arbiter.
// Also provides the helper that turns a one-hot grant into a writeback source.
package regbank_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    reg_addr_t addr;
    reg_data_t data;
  } wb_req_t;

  function automatic wb_src_e grant_src(input logic [1:0] grant);
    return grant[1] ? WB_LSU : WB_ALU;
  endfunction

endpackage

// File: rtl/regbank_wb_arbiter_if.sv
// Two-requester writeback request bus: valid/ready handshake plus per-requester payload.
interface regbank_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [ADDR_W-1:0] req_addr0;
  logic [ADDR_W-1:0] req_addr1;
  logic [DATA_W-1:0] req_data0;
  logic [DATA_W-1:0] req_data1;

  modport master (
    output req_valid, req_addr0, req_addr1, req_data0, req_data1,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_data0, req_data1,
    output req_ready
  );

endinterface

// File: rtl/regbank_wb_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester preferred on contention.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic       ptr_r;
  logic [1:0] grant_s;

  // Grant decode; reset suppresses all grants.
  always_comb begin
    grant_s = 2'b00;
    if (rst) begin
      grant_s = 2'b00;
    end else begin
      case (req)
        2'b01:   grant_s = 2'b01;
        2'b10:   grant_s = 2'b10;
        2'b11:   grant_s = ptr_r ? 2'b10 : 2'b01;
        default: grant_s = 2'b00;
      endcase
    end
  end

  // After a transfer, prefer the requester that lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= 1'b0;
    end else if (advance) begin
      ptr_r <= grant_s[0];
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Writeback port arbiter for the register bank: registered write port plus per-register
// busy scoreboard that decode uses for RAW stalls.
module regbank_wb_arbiter
  import regbank_pkg::*;
#(
  parameter int NUM_REGS = regbank_pkg::NUM_REGS,
  parameter int ADDR_W   = regbank_pkg::ADDR_W,
  parameter int DATA_W   = regbank_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  regbank_wb_arbiter_if.slave  req,
  input  logic                 issue_valid,
  input  logic [ADDR_W-1:0]    issue_rd,
  output logic [ADDR_W-1:0]    w_addr,
  output logic                 write_en,
  output logic [DATA_W-1:0]    write_data,
  output logic [NUM_REGS-1:0]  busy
);

  logic [1:0]          grant_s;
  logic                xfer_s;
  wb_src_e             src_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] clr_s;

  logic                write_en_r;
  logic [ADDR_W-1:0]   w_addr_r;
  logic [DATA_W-1:0]   write_data_r;
  logic [NUM_REGS-1:0] busy_r;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req.req_valid),
    .advance (xfer_s),
    .grant   (grant_s)
  );

  assign req.req_ready = grant_s;
  assign xfer_s        = |(req.req_valid & grant_s);

  // Select the granted requester's payload.
  always_comb begin
    src_s      = grant_src(grant_s);
    sel_addr_s = req.req_addr0;
    sel_data_s = req.req_data0;
    case (src_s)
      WB_ALU: begin
        sel_addr_s = req.req_addr0;
        sel_data_s = req.req_data0;
      end
      WB_LSU: begin
        sel_addr_s = req.req_addr1;
        sel_data_s = req.req_data1;
      end
      default: begin
        sel_addr_s = req.req_addr0;
        sel_data_s = req.req_data0;
      end
    endcase
  end

  // Write-port register stage; writes to x0 are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en_r   <= 1'b0;
      w_addr_r     <= {ADDR_W{1'b0}};
      write_data_r <= {DATA_W{1'b0}};
    end else if (xfer_s) begin
      write_en_r   <= (sel_addr_s != {ADDR_W{1'b0}});
      w_addr_r     <= sel_addr_s;
      write_data_r <= sel_data_s;
    end else begin
      write_en_r   <= 1'b0;
    end
  end

  // Per-register set/clear requests; bit 0 is never set so x0 is never busy.
  always_comb begin
    set_s = {NUM_REGS{1'b0}};
    clr_s = {NUM_REGS{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      set_s[i] = issue_valid && (issue_rd == ADDR_W'(i));
      clr_s[i] = write_en_r  && (w_addr_r == ADDR_W'(i));
    end
  end

  // Scoreboard update; a same-cycle set beats the clear since a newer producer exists.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NUM_REGS{1'b0}};
    end else begin
      busy_r <= (busy_r & ~clr_s) | set_s;
    end
  end

  assign write_en   = write_en_r;
  assign w_addr     = w_addr_r;
  assign write_data = write_data_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Self-checking bench: scenario tasks with inline checks, and a scoreboard queue of
// expected write-port/busy state popped just after each clock edge.
module tb_regbank_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  w_addr;
  logic        write_en;
  logic [31:0] write_data;
  logic [31:0] busy;

  regbank_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) rq ();

  regbank_wb_arbiter #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (rq),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .w_addr      (w_addr),
    .write_en    (write_en),
    .write_data  (write_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        m_we   = 1'b0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic [31:0] m_busy = 32'd0;
  logic        m_ptr  = 1'b0;
  logic [31:0] bank [32] = '{default: 32'h0};

  // Register bank model driven by the DUT's write port.
  always @(posedge clk) begin
    if (write_en === 1'b1) bank[w_addr] <= write_data;
  end

  // Scoreboard monitor: compare state right after each edge.
  always begin
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (write_en !== mon_e.we) begin
        errors++;
        $display("FAIL sb_write_en got %b want %b at %0t", write_en, mon_e.we, $time);
      end
      if (mon_e.we) begin
        checks++;
        if (w_addr !== mon_e.addr || write_data !== mon_e.data) begin
          errors++;
          $display("FAIL sb_payload got x%0d=%h want x%0d=%h at %0t",
                   w_addr, write_data, mon_e.addr, mon_e.data, $time);
        end
      end
      checks++;
      if (busy !== mon_e.busy) begin
        errors++;
        $display("FAIL sb_busy got %h want %h at %0t", busy, mon_e.busy, $time);
      end
    end
  end

  // One cycle of stimulus; leaves the caller at the negedge for inline checks.
  task automatic drive_cycle(input logic r, input logic [1:0] v,
                             input logic [4:0] a0, input logic [31:0] d0,
                             input logic [4:0] a1, input logic [31:0] d1,
                             input logic iv, input logic [4:0] rd);
    logic [1:0]  g;
    logic [31:0] nb;
    exp_t        e;
    @(posedge clk);
    #1;
    rst = r; rq.req_valid = v;
    rq.req_addr0 = a0; rq.req_data0 = d0;
    rq.req_addr1 = a1; rq.req_data1 = d1;
    issue_valid = iv; issue_rd = rd;
    @(negedge clk);
    if (r) begin
      m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_busy = 32'd0; m_ptr = 1'b0;
    end else begin
      case (v)
        2'b01:   g = 2'b01;
        2'b10:   g = 2'b10;
        2'b11:   g = m_ptr ? 2'b10 : 2'b01;
        default: g = 2'b00;
      endcase
      nb = m_busy;
      if (m_we) nb[m_addr] = 1'b0;
      if (iv && rd != 5'd0) nb[rd] = 1'b1;
      m_busy = nb;
      if (g != 2'b00) begin
        m_addr = g[1] ? a1 : a0;
        m_data = g[1] ? d1 : d0;
        m_we   = (m_addr != 5'd0);
        m_ptr  = g[0];
      end else begin
        m_we = 1'b0;
      end
    end
    e.we = m_we; e.addr = m_addr; e.data = m_data; e.busy = m_busy;
    sb.push_back(e);
  endtask

  task automatic idle();
    drive_cycle(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b1, 5'd3);
    checks++;
    if (rq.req_ready !== 2'b00) begin
      errors++; $display("FAIL reset_ready0 got %b want 00", rq.req_ready);
    end
    drive_cycle(1'b1, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b1, 5'd3);
    checks++;
    if (rq.req_ready !== 2'b00 || write_en !== 1'b0 || busy !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got ready=%b we=%b busy=%h want 00/0/0",
               rq.req_ready, write_en, busy);
    end
    drive_cycle(1'b0, 2'b11, 5'd1, 32'h11, 5'd2, 32'h22, 1'b0, 5'd0);
    checks++;
    if (rq.req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant got %b want 01", rq.req_ready);
    end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    drive_cycle(1'b0, 2'b10, 5'd0, 32'd0, 5'd6, 32'h0000_BEEF, 1'b0, 5'd0);
    checks++;
    if (rq.req_ready !== 2'b10) begin
      errors++; $display("FAIL single_lsu got %b want 10", rq.req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      drive_cycle(1'b0, 2'b11, 5'd5, 32'hA5A5_0001, 5'd6, 32'h0000_BEEF, 1'b0, 5'd0);
      checks++;
      if (rq.req_ready !== want) begin
        errors++; $display("FAIL contention_%0d got %b want %b", i, rq.req_ready, want);
      end
    end
  endtask

  task automatic test_x0();
    drive_cycle(1'b0, 2'b01, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b0, 5'd0);
    checks++;
    if (rq.req_ready !== 2'b01) begin
      errors++; $display("FAIL x0_ready got %b want 01", rq.req_ready);
    end
    idle();
    checks++;
    if (write_en !== 1'b0) begin
      errors++; $display("FAIL x0_write_en got %b want 0", write_en);
    end
    idle();
    checks++;
    if (bank[0] !== 32'h0) begin
      errors++; $display("FAIL x0_bank got %h want 0", bank[0]);
    end
  endtask

  task automatic test_scoreboard();
    drive_cycle(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd17);
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) drive_cycle(1'b0, 2'b10, 5'd0, 32'd0, 5'd17, 32'h0000_1234, 1'b0, 5'd0);
      else        idle();
      checks++;
      if (busy[17] !== (c <= 4 ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL busy17_cycle%0d got %b", c, busy[17]);
      end
      if (c == 4) begin
        checks++;
        if (write_en !== 1'b1 || w_addr !== 5'd17) begin
          errors++; $display("FAIL sb_write got we=%b addr=%0d want 1/17", write_en, w_addr);
        end
      end
    end
    checks++;
    if (bank[17] !== 32'h0000_1234) begin
      errors++; $display("FAIL bank17 got %h want 00001234", bank[17]);
    end
  endtask

  task automatic test_collision();
    drive_cycle(1'b0, 2'b01, 5'd18, 32'hCAFE_0018, 5'd0, 32'd0, 1'b0, 5'd0);
    drive_cycle(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd18);
    checks++;
    if (write_en !== 1'b1 || w_addr !== 5'd18) begin
      errors++; $display("FAIL coll_write got we=%b addr=%0d want 1/18", write_en, w_addr);
    end
    idle();
    checks++;
    if (busy !== 32'h0004_0000) begin
      errors++; $display("FAIL coll_busy got %h want 00040000", busy);
    end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1'b1, 2'b10, 5'd0, 32'd0, 5'd9, 32'h0000_9999, 1'b0, 5'd0);
    checks++;
    if (rq.req_ready !== 2'b00) begin
      errors++; $display("FAIL mid_ready got %b want 00", rq.req_ready);
    end
    idle();
    checks++;
    if (busy !== 32'h0 || write_en !== 1'b0) begin
      errors++; $display("FAIL mid_state got busy=%h we=%b want 0/0", busy, write_en);
    end
    drive_cycle(1'b0, 2'b11, 5'd7, 32'h77, 5'd8, 32'h88, 1'b0, 5'd0);
    checks++;
    if (rq.req_ready !== 2'b01) begin
      errors++; $display("FAIL mid_ptr got %b want 01", rq.req_ready);
    end
    idle();
    checks++;
    if (bank[9] !== 32'h0) begin
      errors++; $display("FAIL mid_dropped got %h want 0", bank[9]);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; issue_rd = 5'd0;
    rq.req_valid = 2'b00;
    rq.req_addr0 = 5'd0; rq.req_data0 = 32'd0;
    rq.req_addr1 = 5'd0; rq.req_data1 = 32'd0;
    test_reset();
    test_contention();
    test_x0();
    test_scoreboard();
    test_collision();
    test_reset_mid();
    @(posedge clk);
    #4;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d entries want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
# regbank_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register bank. Two writeback sources share the bank's single write port: requester 0 is the ALU and requester 1 is the load/store unit. The block grants them round-robin and drives `w_addr`, `write_en` and `write_data` from registers. It also tracks a busy bit per register from issue to writeback, which decode uses for RAW-hazard stalls.

## Interface
Parameters:
- `NUM_REGS`, 32, number of architectural registers
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, register data width

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  2  per-requester write request (bit 0 ALU, bit 1 LSU)
- `req_ready`  out  2  per-requester acceptance; a transfer occurs when valid and ready are both high
- `req_addr0`, `req_addr1`  in  ADDR_W  destination register per requester
- `req_data0`, `req_data1`  in  DATA_W  write data per requester
- `issue_valid`  in  1  decode issues an instruction that writes `issue_rd`
- `issue_rd`  in  ADDR_W  destination of the issued instruction
- `w_addr`  out  ADDR_W  to the register bank write address
- `write_en`  out  1  to the register bank write enable
- `write_data`  out  DATA_W  to the register bank write data
- `busy`  out  NUM_REGS  per-register pending-write mask to decode

## Operation
- **Arbitration.** One round-robin pointer `rr_ptr` names the preferred requester.
  - Both valid: grant the `rr_ptr` requester.
  - One valid: grant it.
  - `req_ready[i]` = grant[i]; it is combinational from `req_valid` and `rr_ptr`.
  - After any accepted transfer, `rr_ptr` points to the requester that was not granted.
  - With no transfer, `rr_ptr` holds.
- **Handshake rules.**
  - A requester holds valid, addr and data stable until accepted.
  - Valid must not depend on ready.
  - At most one transfer per cycle.
- **Output stage.** On an accepted transfer, the next-cycle `write_en` = 1, with `w_addr` and `write_data` = the granted payload. With no transfer, `write_en` = 0 and `w_addr`/`write_data` hold their last values.
- **x0 handling.**
  - A request with addr 0 is accepted normally but produces `write_en` = 0.
  - An issue with rd 0 never sets busy; `busy[0]` is constant 0.
- **Scoreboard.**
  - `issue_valid` with rd != 0 sets `busy[rd]` at the next edge.
  - A registered write (`write_en` = 1) clears `busy[w_addr]` at the same edge the bank performs the write.
  - Same register set and cleared in one cycle: set wins, because a newer producer exists.
  - Clears for registers that are not busy are harmless.
- **Reset** (`rst` = 1 at posedge):
  - `rr_ptr` = 0 (ALU preferred); `write_en`, `w_addr`, `write_data` = 0; `busy` = 0.
  - While `rst` is high, `req_ready` = 0 and issues are ignored.
  - A request pending when reset asserts is dropped. The requester re-presents it after reset; it is not auto-replayed.

## Timing
- Transfer accepted in cycle N → `write_en`/`w_addr`/`write_data` valid in cycle N+1 → bank updated at the posedge ending N+1.
- The `busy` bit for that register reads 0 in N+2. A bank read in N+2 returns the new data.
- Issue in cycle N → `busy[rd]` = 1 in N+1.
- Back-to-back throughput is one write per cycle. Under continuous contention the requesters alternate, so each sees ready every other cycle, which bounds starvation to 1 cycle.
- No combinational path from `req_*` to `write_*` or `busy`. The only combinational path is `req_valid` → `req_ready`.

## Structure
- Package `regbank_pkg`:
  - `ADDR_W`, `DATA_W`, `NUM_REGS` constants
  - `typedef` `reg_addr_t`, `reg_data_t`
  - enum `wb_src_e` {`WB_ALU`=0, `WB_LSU`=1}
  - a `wb_req_t` struct (addr, data)
- Sub-module `rr_arbiter2`: a 2-way round-robin grant with pointer register; inputs are `clk`, `rst`, `req[1:0]`, `advance`; output is `grant[1:0]`.
- Top level holds the output registers and the scoreboard. The register bank itself stays outside this block.

## Test plan
- **Reset:** hold `rst` 2 cycles with `req_valid`=2'b11 → `req_ready`=0, `write_en`=0, `busy`=0. After release, the first grant goes to ALU.
- **Contention:** both valid for 4 cycles, ALU (x5, 0xA5A5_0001), LSU (x6, 0x0000_BEEF) → grants alternate ALU, LSU, ALU, LSU. `write_en` is high in cycles 1–4 with the matching addr/data.
- **x0 filter:** ALU writes x0 = 0xFFFF_FFFF → `req_ready`=1, next cycle `write_en`=0. Bank x0 stays 0.
- **Scoreboard timing:** issue rd=x17 at cycle 0, then LSU writes x17 = 0x1234 at cycle 3 → `busy[17]`=1 in cycles 1–4 and 0 from cycle 5. Bank x17 = 0x1234 at cycle 5.
- **Set/clear collision:** a write to x18 is registered in the same cycle a new issue names rd=x18 → after the edge, `busy[18]`=1.
- **Reset mid-operation:** assert `rst` while LSU is valid and `busy`=0x0004_0000 → next cycle `busy`=0, `write_en`=0, `rr_ptr`=0. The LSU request is not written.
